// File: rtl/mul_pkg.sv
// Shared encodings and helpers for the iterative M-extension multiplier.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Number of CALC cycles needed to consume all multiplier bits.
  function automatic int iter_count(input int xlen, input int bpc);
    return xlen / bpc;
  endfunction

endpackage

// File: rtl/mul_step.sv
// Combinational partial-product step: adds a_mag * b_bits, placed at shift_i,
// onto the double-width accumulator.
module mul_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 4,
  parameter int SW   = 6
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   a_mag_i,
  input  logic [BPC-1:0]    b_bits_i,
  input  logic [SW-1:0]     shift_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] row [BPC];
  logic [2*XLEN-1:0] pp_sum;

  assign a_ext = {{XLEN{1'b0}}, a_mag_i};

  // One shifted copy of the multiplicand per multiplier bit in the slice.
  for (genvar gi = 0; gi < BPC; gi++) begin : g_row
    assign row[gi] = b_bits_i[gi] ? (a_ext << gi) : '0;
  end

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < BPC; i++) begin
      pp_sum = pp_sum + row[i];
    end
  end

  assign acc_o = acc_i + (pp_sum << shift_i);

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) retiring BPC multiplier
// bits per cycle, with accept/busy/ready handshake, flush and zero fast path.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BPC       = 4,
  parameter int ZERO_FAST = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N_ITER = iter_count(XLEN, BPC);
  localparam int CW     = $clog2(N_ITER + 1);
  localparam int SW     = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sign_a, sign_b, accept, zero_hit;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [SW-1:0]     shift;
  logic [2*XLEN-1:0] acc_step, acc_fin;

  mul_step #(
    .XLEN (XLEN),
    .BPC  (BPC),
    .SW   (SW)
  ) u_step (
    .acc_i    (acc_q),
    .a_mag_i  (a_mag_q),
    .b_bits_i (b_mag_q[BPC-1:0]),
    .shift_i  (shift),
    .acc_o    (acc_step)
  );

  always_comb begin
    sign_a   = ((op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU)) && a_i[XLEN-1];
    sign_b   = (op_i == MUL_OP_MULH) && b_i[XLEN-1];
    a_mag_in = sign_a ? -a_i : a_i;
    b_mag_in = sign_b ? -b_i : b_i;
    accept   = req_i && !flush_i && ((state_q == IDLE) || (state_q == DONE));
    zero_hit = (ZERO_FAST != 0) && ((a_i == '0) || (b_i == '0));
    // Iteration k (counting up from 0) places its slice at bit k*BPC.
    shift    = SW'((N_ITER - int'(cnt_q)) * BPC);
    acc_fin  = neg_q ? -acc_step : acc_step;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_step;
          b_mag_d = b_mag_q >> BPC;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = DONE;
            result_d = (op_q == MUL_OP_MUL) ? acc_fin[XLEN-1:0] : acc_fin[2*XLEN-1:XLEN];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A new request overrides the DONE->IDLE return for back-to-back issue.
    if (accept) begin
      op_d    = op_i;
      neg_d   = sign_a ^ sign_b;
      a_mag_d = a_mag_in;
      b_mag_d = b_mag_in;
      acc_d   = '0;
      cnt_d   = CW'(N_ITER);
      if (zero_hit) begin
        state_d  = DONE;
        result_d = '0;
      end else begin
        state_d = CALC;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == CALC);
  assign ready_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed, table-driven bench for mul_iter_unit across four configurations:
// default, ZERO_FAST=0, BPC=1 and BPC=32.
module tb_mul_iter_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req;
  logic        flush_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [3:0]  busy, rdy;
  logic [31:0] res [4];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk_i = ~clk_i;

  mul_iter_unit #(.XLEN(32), .BPC(4), .ZERO_FAST(1)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req[0]), .flush_i(flush_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy[0]), .ready_o(rdy[0]), .result_o(res[0]));
  mul_iter_unit #(.XLEN(32), .BPC(4), .ZERO_FAST(0)) u_zf0 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req[1]), .flush_i(flush_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy[1]), .ready_o(rdy[1]), .result_o(res[1]));
  mul_iter_unit #(.XLEN(32), .BPC(1), .ZERO_FAST(1)) u_b1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req[2]), .flush_i(flush_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy[2]), .ready_o(rdy[2]), .result_o(res[2]));
  mul_iter_unit #(.XLEN(32), .BPC(32), .ZERO_FAST(1)) u_b32 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req[3]), .flush_i(flush_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy[3]), .ready_o(rdy[3]), .result_o(res[3]));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one op on instance idx; check latency, result and busy during CALC.
  task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_bad;
    lat = -1;
    busy_bad = 0;
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; req[idx] = 1'b1;
    @(posedge clk_i);
    #1 req[idx] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      if (rdy[idx]) begin
        lat = c;
        break;
      end
      if (busy[idx] !== 1'b1) busy_bad++;
    end
    $display("inst=%0d op=%0d a=%h b=%h result=%h lat=%0d", idx, op, a, b, res[idx], lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", res[idx], exp_res);
    chk("busy_in_calc", 32'(busy_bad), 32'd0);
  endtask

  initial begin
    int bad;
    int lat_n;
    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'h0000002A};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000};
    vecs[2]  = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
    vecs[4]  = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
    vecs[5]  = '{2'b01, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF};
    vecs[6]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
    vecs[7]  = '{2'b00, 32'h12345678,   32'h00000010,   32'h23456780};
    vecs[8]  = '{2'b10, 32'h80000000,   32'd2,          32'hFFFFFFFF};
    vecs[9]  = '{2'b01, 32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF};
    vecs[10] = '{2'b00, 32'd0,          32'h00001234,   32'h00000000};
    vecs[11] = '{2'b01, 32'd5,          32'd0,          32'h00000000};

    rst_i = 1'b0; req = '0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_result", res[0], 32'd0);
    rst_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      lat_n = ((vecs[i].a == 0) || (vecs[i].b == 0)) ? 1 : 9;
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, lat_n);
      if (i < 6) begin
        run_op(2, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (lat_n == 1) ? 1 : 33);
        run_op(3, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (lat_n == 1) ? 1 : 2);
      end
    end

    // Zero operand without the fast path iterates the full count.
    run_op(1, 2'b00, 32'd0, 32'h00001234, 32'd0, 9);

    // Flush in cycle 4 of a MUL 3x5; fresh MUL 2x2 accepted in cycle 6.
    bad = 0;
    @(negedge clk_i);
    op_i = 2'b00; a_i = 32'd3; b_i = 32'd5; req[0] = 1'b1;
    @(posedge clk_i);
    #1 req[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      if (c == 4) flush_i = 1'b1;
      if (c == 5) begin
        flush_i = 1'b0;
        chk("flush_busy_low", 32'(busy[0]), 32'd0);
      end else if (busy[0] !== 1'b1) bad++;
      if (rdy[0]) bad++;
    end
    chk("flush_no_ready", 32'(bad), 32'd0);
    run_op(0, 2'b00, 32'd2, 32'd2, 32'd4, 9);

    // Back-to-back: second request held on req and taken in the DONE cycle.
    bad = 0;
    @(negedge clk_i);
    op_i = 2'b11; a_i = 32'hFFFFFFFF; b_i = 32'd2; req[0] = 1'b1;
    @(posedge clk_i);
    #1 op_i = 2'b00; a_i = 32'd9; b_i = 32'd9;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk_i);
      if (c == 9) begin
        chk("b2b_first_ready", 32'(rdy[0]), 32'd1);
        chk("b2b_first_result", res[0], 32'h00000001);
      end else if (c == 18) begin
        chk("b2b_second_ready", 32'(rdy[0]), 32'd1);
        chk("b2b_second_result", res[0], 32'h00000051);
        req[0] = 1'b0;
      end else if (rdy[0]) bad++;
    end
    $display("inst=0 back-to-back MULHU then MUL result=%h", res[0]);
    chk("b2b_no_extra_ready", 32'(bad), 32'd0);
    @(negedge clk_i);
    chk("b2b_idle_after", 32'({busy[0], rdy[0]}), 32'd0);

    // Asynchronous reset in cycle 5 of an operation on the default and BPC=1 units.
    @(negedge clk_i);
    op_i = 2'b11; a_i = 32'hFFFFFFFF; b_i = 32'hFFFFFFFF; req[0] = 1'b1; req[2] = 1'b1;
    @(posedge clk_i);
    #1 req = '0;
    repeat (5) @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(rdy), 32'd0);
    chk("arst_result_main", res[0], 32'd0);
    chk("arst_result_b1", res[2], 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (rdy != 4'd0) bad++;
    end
    chk("arst_no_ready", 32'(bad), 32'd0);
    run_op(0, 2'b00, 32'd7, 32'd6, 32'h0000002A, 9);
    run_op(2, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op(3, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
